pic_host_master: RTL

- CPU-side bus initiator for the 8259-style PIC: the master end of its write and interrupt-acknowledge interface.
- After start_init, writes the ICW1..ICW4 init sequence and an OCW1 mask over wr/a0/data, then forwards host OCW writes.
- On a raised INT line, runs the two-pulse INTA sequence and captures the 8-bit vector the PIC drives during the second pulse.
- Sits between the host/processor model and the PIC top level.

---
 rtl/pic_host_master.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/pic_host_master.sv
// Host-side bus master for an 8259-style PIC.
// Runs the ICW/OCW1 init sequence, forwards host OCW writes and performs
// the two-pulse interrupt-acknowledge cycle that captures the vector byte.
module pic_host_master #(
  parameter logic [4:0] VECTOR_BASE = 5'b00100,
  parameter bit         SNGL        = 1'b1,
  parameter bit         IC4         = 1'b1,
  parameter logic [7:0] ICW3_VAL    = 8'h00,
  parameter logic [7:0] ICW4_VAL    = 8'h01,
  parameter logic [7:0] INIT_MASK   = 8'h00,
  parameter int         STROBE_LEN  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_init,
  output logic       init_done,
  output logic       busy,
  input  logic       ocw_req,
  input  logic       ocw_a0,
  input  logic [7:0] ocw_data,
  output logic       ocw_ack,
  input  logic       INT,
  output logic       INTA,
  output logic       wr,
  output logic       a0,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in,
  output logic [7:0] vector_out,
  output logic       vector_valid
);

  localparam int            CW       = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_LEN - 1);

  localparam logic [7:0] ICW1_VAL = {3'b000, 1'b1, 2'b00, SNGL, IC4};
  localparam logic [7:0] ICW2_VAL = {VECTOR_BASE, 3'b000};

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    A_PULSE1,
    A_GAP,
    A_PULSE2
  } state_t;

  typedef enum logic [2:0] {
    STEP_ICW1,
    STEP_ICW2,
    STEP_ICW3,
    STEP_ICW4,
    STEP_OCW1
  } step_t;

  state_t        state;
  step_t         step;
  step_t         next_step;
  logic [CW-1:0] cnt;
  logic          init_active;
  logic          host_txn;
  logic          step_a0;
  logic [7:0]    step_byte;

  // Register-select and byte for the current init step.
  always_comb begin
    step_a0   = 1'b1;
    step_byte = 8'h00;
    case (step)
      STEP_ICW1: begin
        step_a0   = 1'b0;
        step_byte = ICW1_VAL;
      end
      STEP_ICW2: step_byte = ICW2_VAL;
      STEP_ICW3: step_byte = ICW3_VAL;
      STEP_ICW4: step_byte = ICW4_VAL;
      STEP_OCW1: step_byte = INIT_MASK;
      default: begin
        step_a0   = 1'b1;
        step_byte = 8'h00;
      end
    endcase
  end

  // Which init step follows the current one; ICW3/ICW4 are skipped by configuration.
  always_comb begin
    next_step = STEP_OCW1;
    case (step)
      STEP_ICW1: next_step = STEP_ICW2;
      STEP_ICW2: next_step = !SNGL ? STEP_ICW3 : (IC4 ? STEP_ICW4 : STEP_OCW1);
      STEP_ICW3: next_step = IC4 ? STEP_ICW4 : STEP_OCW1;
      default:   next_step = STEP_OCW1;
    endcase
  end

  // Bus sequencer: arbitration in IDLE, write and INTA timing, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      step         <= STEP_ICW1;
      cnt          <= '0;
      init_active  <= 1'b0;
      host_txn     <= 1'b0;
      init_done    <= 1'b0;
      busy         <= 1'b0;
      ocw_ack      <= 1'b0;
      INTA         <= 1'b1;
      wr           <= 1'b1;
      a0           <= 1'b0;
      data_out     <= 8'h00;
      data_oe      <= 1'b0;
      vector_out   <= 8'h00;
      vector_valid <= 1'b0;
    end else begin
      ocw_ack      <= 1'b0;
      vector_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_init) begin
            init_active <= 1'b1;
            init_done   <= 1'b0;
            host_txn    <= 1'b0;
            step        <= STEP_ICW1;
            state       <= W_SETUP;
            busy        <= 1'b1;
            a0          <= 1'b0;
            data_out    <= ICW1_VAL;
            data_oe     <= 1'b1;
          end else if (init_active) begin
            state    <= W_SETUP;
            busy     <= 1'b1;
            a0       <= step_a0;
            data_out <= step_byte;
            data_oe  <= 1'b1;
          end else if (init_done && ocw_req) begin
            host_txn <= 1'b1;
            state    <= W_SETUP;
            busy     <= 1'b1;
            a0       <= ocw_a0;
            data_out <= ocw_data;
            data_oe  <= 1'b1;
          end else if (init_done && INT) begin
            state <= A_PULSE1;
            busy  <= 1'b1;
            INTA  <= 1'b0;
            cnt   <= '0;
          end
        end
        W_SETUP: begin
          state <= W_STROBE;
          wr    <= 1'b0;
          cnt   <= '0;
        end
        W_STROBE: begin
          if (cnt == CNT_LAST) begin
            state   <= W_HOLD;
            wr      <= 1'b1;
            ocw_ack <= host_txn;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        W_HOLD: begin
          state    <= IDLE;
          busy     <= 1'b0;
          data_oe  <= 1'b0;
          a0       <= 1'b0;
          data_out <= 8'h00;
          if (host_txn) begin
            host_txn <= 1'b0;
          end else if (step == STEP_OCW1) begin
            init_active <= 1'b0;
            init_done   <= 1'b1;
          end else begin
            step <= next_step;
          end
        end
        A_PULSE1: begin
          if (cnt == CNT_LAST) begin
            state <= A_GAP;
            INTA  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        A_GAP: begin
          state <= A_PULSE2;
          INTA  <= 1'b0;
          cnt   <= '0;
        end
        A_PULSE2: begin
          if (cnt == CNT_LAST) begin
            state        <= IDLE;
            busy         <= 1'b0;
            INTA         <= 1'b1;
            vector_out   <= data_in;
            vector_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          INTA    <= 1'b1;
          wr      <= 1'b1;
          data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
